// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI SRAM responder with sampled SCK/CS/SIO and a backdoor port.
module idli_sqi_mem_m #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_mem_gck,
    input  logic              i_mem_rst,
    input  logic              i_mem_sck,
    input  logic              i_mem_cs,
    input  logic [3:0]        i_mem_sio,
    output logic [3:0]        o_mem_sio,
    output logic              o_mem_sio_oe,
    input  logic              i_mem_bd_en,
    input  logic [ADDR_W-1:0] i_mem_bd_addr,
    input  logic [7:0]        i_mem_bd_data,
    output logic [7:0]        o_mem_bd_data
);
    typedef enum logic [2:0] {IDLE, INSTR, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

    logic [7:0]                  mem_q [1 << ADDR_W];
    logic [SYNC_STAGES-1:0]      sck_sync_q, cs_sync_q, vld_q;
    logic [SYNC_STAGES-1:0][3:0] sio_sync_q;
    logic                        sck_prev_q, armed_q, rd_q, oe_q;
    logic [3:0]                  ins_q, wr_hi_q, sio_out_q;
    logic [1:0]                  n_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [7:0]                  bd_q;
    state_t                      state_q;

    logic       sck_s, cs_s, rise, fall, we;
    logic [3:0] sio_s;
    logic [7:0] rd_byte;

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sio_s   = sio_sync_q[SYNC_STAGES-1];
    assign rise    = ~cs_s & sck_s & ~sck_prev_q;
    assign fall    = ~cs_s & ~sck_s & sck_prev_q;
    assign rd_byte = mem_q[addr_q];
    assign we      = (state_q == WR_DATA) & rise & n_q[0];

    assign o_mem_sio     = sio_out_q;
    assign o_mem_sio_oe  = oe_q;
    assign o_mem_bd_data = bd_q;

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sio_sync_q <= '0;
            vld_q      <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i_mem_sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], i_mem_cs};
            sio_sync_q <= {sio_sync_q[SYNC_STAGES-2:0], i_mem_sio};
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q <= sck_s;
        end
    end

    // The chain's reset value of CS=1 must not arm a CS held low across reset.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            n_q       <= '0;
            armed_q   <= 1'b0;
            rd_q      <= 1'b0;
            ins_q     <= '0;
            wr_hi_q   <= '0;
            sio_out_q <= '0;
            oe_q      <= 1'b0;
        end else if (cs_s) begin
            state_q <= IDLE;
            n_q     <= '0;
            oe_q    <= 1'b0;
            if (vld_q[SYNC_STAGES-1]) armed_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (armed_q) state_q <= INSTR;
                INSTR: if (rise) begin
                    ins_q <= sio_s;
                    n_q   <= n_q + 2'd1;
                    if (n_q[0]) begin
                        n_q     <= '0;
                        rd_q    <= sio_s[0];
                        state_q <= (ins_q == 4'h0 && (sio_s == 4'h3 || sio_s == 4'h2)) ? ADDR : IGNORE;
                    end
                end
                ADDR: if (rise) begin
                    addr_q <= {addr_q[ADDR_W-5:0], sio_s};
                    n_q    <= n_q + 2'd1;
                    if (n_q == 2'd3) begin
                        n_q     <= '0;
                        state_q <= rd_q ? DUMMY : WR_DATA;
                    end
                end
                DUMMY: if (rise) begin
                    n_q <= n_q + 2'd1;
                    if (n_q[0]) begin
                        n_q     <= '0;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: if (fall) begin
                    oe_q      <= 1'b1;
                    sio_out_q <= n_q[0] ? rd_byte[3:0] : rd_byte[7:4];
                    n_q       <= {1'b0, ~n_q[0]};
                    if (n_q[0]) addr_q <= addr_q + ADDR_W'(1);
                end
                WR_DATA: if (rise) begin
                    n_q <= {1'b0, ~n_q[0]};
                    if (n_q[0]) addr_q <= addr_q + ADDR_W'(1);
                    else wr_hi_q <= sio_s;
                end
                default: ;
            endcase
        end
    end

    // Backdoor write is issued last so it wins on an address collision.
    always_ff @(posedge i_mem_gck) begin
        if (we) mem_q[addr_q] <= {wr_hi_q, sio_s};
        if (i_mem_bd_en) mem_q[i_mem_bd_addr] <= i_mem_bd_data;
    end

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) bd_q <= '0;
        else bd_q <= mem_q[i_mem_bd_addr];
    end
endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// tb_idli_sqi_mem_m: directed SQI read/write/wrap/abort checks against hand-computed values.
module tb_idli_sqi_mem_m;
    logic        clk = 1'b0;
    logic        rst, sck, cs, oe, bd_en;
    logic [3:0]  sio_i, sio_o;
    logic [15:0] bd_addr;
    logic [7:0]  bd_wdata, bd_rdata;
    int          total = 0, bad = 0;

    idli_sqi_mem_m dut (
        .i_mem_gck(clk), .i_mem_rst(rst), .i_mem_sck(sck), .i_mem_cs(cs),
        .i_mem_sio(sio_i), .o_mem_sio(sio_o), .o_mem_sio_oe(oe),
        .i_mem_bd_en(bd_en), .i_mem_bd_addr(bd_addr), .i_mem_bd_data(bd_wdata),
        .o_mem_bd_data(bd_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sclk(input logic [3:0] d, output logic [3:0] s, output logic o);
        sio_i = d;
        #78 s = sio_o;
        o = oe;
        #2 sck = 1'b1;
        #80 sck = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        logic [3:0] s;
        logic o;
        sclk(d, s, o);
    endtask

    task automatic cs_low;
        cs = 1'b0;
        #80;
    endtask

    task automatic cs_high;
        cs = 1'b1;
        #160;
    endtask

    task automatic bd_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_wdata = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic bd_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
        @(negedge clk);
        bd_addr = a;
        @(negedge clk);
        chk(tag, {8'h0, bd_rdata}, {8'h0, e});
    endtask

    task automatic start(input logic [3:0] ins, input logic [15:0] a);
        cs_low();
        send(4'h0); send(ins);
        send(a[15:12]); send(a[11:8]); send(a[7:4]); send(a[3:0]);
    endtask

    task automatic rd_nib(input string tag, input logic [3:0] e);
        logic [3:0] s;
        logic o;
        sclk(4'h0, s, o);
        chk({tag, "_oe"}, {15'h0, o}, 16'h1);
        chk(tag, {12'h0, s}, {12'h0, e});
    endtask

    task automatic rd_start(input logic [15:0] a);
        logic [3:0] s;
        logic o;
        start(4'h3, a);
        sclk(4'h0, s, o);
        chk("dummy0_oe", {15'h0, o}, 16'h0);
        sclk(4'h0, s, o);
        chk("dummy1_oe", {15'h0, o}, 16'h0);
    endtask

    initial begin
        logic [3:0] s;
        logic o;
        rst = 1'b1; sck = 1'b0; cs = 1'b1; sio_i = '0;
        bd_en = 1'b0; bd_addr = '0; bd_wdata = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("rst_oe", {15'h0, oe}, 16'h0);
        chk("rst_sio", {12'h0, sio_o}, 16'h0);
        chk("rst_bd", {8'h0, bd_rdata}, 16'h0);
        #200;

        bd_wr(16'h1234, 8'hA5);
        bd_wr(16'h1235, 8'h3C);
        rd_start(16'h1234);
        rd_nib("rd0", 4'hA); rd_nib("rd1", 4'h5); rd_nib("rd2", 4'h3); rd_nib("rd3", 4'hC);
        cs_high();
        chk("rd_end_oe", {15'h0, oe}, 16'h0);

        start(4'h2, 16'h0010);
        send(4'h7); send(4'hE); send(4'h1); send(4'h9);
        cs_high();
        bd_chk("wr_10", 16'h0010, 8'h7E);
        bd_chk("wr_11", 16'h0011, 8'h19);

        bd_wr(16'hFFFF, 8'h12);
        bd_wr(16'h0000, 8'h34);
        rd_start(16'hFFFF);
        rd_nib("wrap0", 4'h1); rd_nib("wrap1", 4'h2); rd_nib("wrap2", 4'h3); rd_nib("wrap3", 4'h4);
        cs_high();

        bd_wr(16'h0020, 8'h55);
        start(4'h2, 16'h0020);
        send(4'hA);
        cs_high();
        bd_chk("partial", 16'h0020, 8'h55);
        rd_start(16'h1234);
        rd_nib("after_partial0", 4'hA); rd_nib("after_partial1", 4'h5);
        cs_high();

        cs_low();
        send(4'h0); send(4'h5);
        for (int i = 0; i < 8; i++) begin
            sclk(4'hF, s, o);
            chk("bad_ins_oe", {15'h0, o}, 16'h0);
        end
        cs_high();
        bd_chk("bad_ins_mem", 16'h1234, 8'hA5);
        bd_chk("bad_ins_mem2", 16'h0010, 8'h7E);

        rd_start(16'h1234);
        rd_nib("pre_rst0", 4'hA);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_oe", {15'h0, oe}, 16'h0);
        for (int i = 0; i < 6; i++) begin
            sclk(4'h3, s, o);
            chk("held_cs_oe", {15'h0, o}, 16'h0);
        end
        cs_high();
        rd_start(16'h1235);
        rd_nib("post_rst0", 4'h3); rd_nib("post_rst1", 4'hC);
        cs_high();

        bd_wr(16'h0040, 8'h11);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = 16'h0040; bd_wdata = 8'h99;
        @(negedge clk);
        bd_en = 1'b0;
        chk("bd_prewrite", {8'h0, bd_rdata}, 16'h0011);
        @(negedge clk);
        chk("bd_postwrite", {8'h0, bd_rdata}, 16'h0099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
